pwm_dac_driver: RTL and testbench
=================================

// Module: pwm_dac_driver
// PURPOSE
//  Downstream consumer of the sine generator: paces sample requests, converts each signed sample to PWM duty.
//  Emits one next_data_strobe_o per PWM period; captures the returned sample on data_valid_strobe_i.
//  Updates duty only on period boundaries, so pwm_o never glitches mid-period.
//  pwm_o drives the off-chip RC low-pass; the result is the analog waveform output of the chip.
// PARAMETERS
//  N_FRAC  7  sample is signed [N_FRAC:0]; PWM counter width W = N_FRAC+1, period = 2^W cycles
// PORTS
//  clk_i               in   1         system clock, all logic on rising edge
//  rst_i               in   1         synchronous, active-low reset
//  enable_i            in   1         1 = run PWM and sample requests; 0 = park
//  data_i              in   N_FRAC+1  signed sample from sine generator (data_o)
//  data_valid_strobe_i in   1         one-cycle pulse, data_i valid
//  next_data_strobe_o  out  1         one-cycle request for next sample (to next_data_strobe_i)
//  pwm_o               out  1         registered PWM output
//  underrun_o          out  1         sticky underrun flag (only with PWM_UNDERRUN_FLAG_EN)
// BEHAVIOUR
//  Reset (rst_i==0 at edge): cnt=0, state=S_IDLE, duty=2^N_FRAC (mid-scale), pending=0.
//   Outputs after reset: pwm_o=0, next_data_strobe_o=0, underrun_o=0.
//  Counter: W-bit cnt, +1 per cycle while enable_i=1; wraps 2^W-1 -> 0. "wrap cycle" = cnt==2^W-1.
//  Conversion: duty = {~data_i[N_FRAC], data_i[N_FRAC-1:0]} (offset binary). -128->0, 0->128, 127->255.
//  pwm_o <= enable_i & (cnt < duty). One-cycle lag vs cnt.
//   duty 0 -> constant low; duty 2^W-1 -> high 2^W-1 of 2^W cycles.
//  FSM:
//   S_IDLE: enable_i & cnt==0 -> next_data_strobe_o=1 (registered pulse, exactly 1 cycle); -> S_WAIT.
//   S_WAIT: data_valid_strobe_i -> pending<=converted data_i; -> S_HOLD.
//    At the wrap cycle still without valid -> underrun event; duty unchanged; -> S_IDLE.
//   S_HOLD: further valid strobes ignored (first sample wins).
//    At the wrap cycle: duty<=pending; -> S_IDLE.
//   Exactly one request per period; a new request is issued at cnt==0 even after an underrun.
//  Simultaneous events:
//   S_WAIT with valid in the wrap cycle -> duty<=converted data_i directly; no underrun; -> S_IDLE.
//   data_valid_strobe_i in S_IDLE -> ignored.
//  enable_i=0 (any time, incl. mid-period): next edge cnt=0, state=S_IDLE, pwm_o=0, strobe=0.
//   pending is discarded, duty retained. On re-enable, first request issues in the first enabled cycle (cnt==0).
//  Reset mid-operation: same as power-on reset, next edge; an in-flight sample arriving later is ignored (S_IDLE).
//  Upstream latency must be < 2^W-1 cycles after request, else underrun.
// CONFIGURATION
//  PWM_UNDERRUN_FLAG_EN defined: underrun_o port present; set on any underrun event.
//   Stays set until reset; not cleared by enable_i.
//  Undefined: port absent, no flag register. Underrun handling (hold duty) is identical.
// STRUCTURE
//  Shared header wave_gen_defs.vh (include-guarded) holds:
//   FSM state encodings S_IDLE/S_WAIT/S_HOLD (2 bits); default N_FRAC.
//   offset-binary conversion macro, also reusable by other output stages.
//  One sub-module: pwm_counter (W-bit counter with enable/clear, outputs cnt and wrap flag).
//  FSM, duty/pending registers and comparator stay in pwm_dac_driver.
// TESTING
//  T1 Reset: hold rst_i=0 3 cycles -> pwm_o=0, strobe=0, underrun_o=0; after release with enable=1, first strobe in cycle 1.
//  T2 Steady: reply data_i=0 5 cycles after each strobe -> from 2nd period pwm_o high exactly 128 of 256 cycles;
//     strobes spaced 256 cycles apart.
//  T3 Extremes: data_i=-128 -> pwm_o low entire period; data_i=127 -> high 255/256; change applies only at period start.
//  T4 Underrun: withhold valid one period -> duty held, underrun_o=1 (with macro), next strobe still at cnt==0;
//     valid at wrap cycle -> new duty next period, no underrun.
//  T5 Double valid: two strobes of 64 then -64 in one period -> duty from 64 (192 high cycles).
//  T6 Enable drop mid-period at cnt=100 -> pwm_o=0 next cycle, cnt=0;
//     re-enable -> strobe immediately, previous duty kept until new sample loads.

Source files
------------

// File: rtl/pwm_dac_driver_pkg.sv
// Shared definitions for the PWM DAC driver: FSM state encoding and default sample width.
package pwm_dac_driver_pkg;

    localparam int N_FRAC_DEFAULT = 7;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } state_t;

endpackage

// File: rtl/pwm_dac_driver_counter.sv
// Free-running W-bit PWM period counter; held at zero while disabled, flags the last cycle of each period.
module pwm_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         enable,
    output logic [W-1:0] cnt,
    output logic         wrap
);

    always_ff @(posedge clk) begin
        if (!rst_n || !enable) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign wrap = enable && (cnt == '1);

endmodule

// File: rtl/pwm_dac_driver.sv
// PWM DAC driver: requests one sample per PWM period and loads its duty on period boundaries.
// Optional sticky underrun flag port enabled by defining PWM_UNDERRUN_FLAG_EN.
module pwm_dac_driver
    import pwm_dac_driver_pkg::*;
#(
    parameter int N_FRAC = N_FRAC_DEFAULT
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              enable_i,
    input  logic [N_FRAC:0]   data_i,
    input  logic              data_valid_strobe_i,
    output logic              next_data_strobe_o,
    output state_t            state_o,
`ifdef PWM_UNDERRUN_FLAG_EN
    output logic              underrun_o,
`endif
    output logic              pwm_o
);

    localparam int W = N_FRAC + 1;
    localparam logic [W-1:0] DUTY_MID = {1'b1, {N_FRAC{1'b0}}};

    logic [W-1:0] cnt;
    logic         wrap;
    state_t       state, state_next;
    logic [W-1:0] duty, duty_next;
    logic [W-1:0] pending, pending_next;
    logic [W-1:0] sample_duty;
    logic         strobe, strobe_next;
    logic         pwm;
`ifdef PWM_UNDERRUN_FLAG_EN
    logic         underrun_event;
    logic         underrun;
`endif

    pwm_counter #(.W(W)) u_counter (
        .clk    (clk_i),
        .rst_n  (rst_i),
        .enable (enable_i),
        .cnt    (cnt),
        .wrap   (wrap)
    );

    // Signed two's complement to offset binary: flip the sign bit.
    assign sample_duty = {~data_i[N_FRAC], data_i[N_FRAC-1:0]};

    always_comb begin
        state_next   = state;
        duty_next    = duty;
        pending_next = pending;
        strobe_next  = 1'b0;
`ifdef PWM_UNDERRUN_FLAG_EN
        underrun_event = 1'b0;
`endif
        if (enable_i) begin
            case (state)
                S_IDLE: begin
                    if (cnt == '0) begin
                        strobe_next = 1'b1;
                        state_next  = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (data_valid_strobe_i) begin
                        // A sample landing in the wrap cycle goes straight to duty.
                        if (wrap) begin
                            duty_next  = sample_duty;
                            state_next = S_IDLE;
                        end else begin
                            pending_next = sample_duty;
                            state_next   = S_HOLD;
                        end
                    end else if (wrap) begin
`ifdef PWM_UNDERRUN_FLAG_EN
                        underrun_event = 1'b1;
`endif
                        state_next = S_IDLE;
                    end
                end
                S_HOLD: begin
                    if (wrap) begin
                        duty_next  = pending;
                        state_next = S_IDLE;
                    end
                end
                default: state_next = S_IDLE;
            endcase
        end else begin
            state_next   = S_IDLE;
            pending_next = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state   <= S_IDLE;
            duty    <= DUTY_MID;
            pending <= '0;
            strobe  <= 1'b0;
            pwm     <= 1'b0;
        end else begin
            state   <= state_next;
            duty    <= duty_next;
            pending <= pending_next;
            strobe  <= strobe_next;
            pwm     <= enable_i && (cnt < duty);
        end
    end

`ifdef PWM_UNDERRUN_FLAG_EN
    // Sticky until reset; disabling the driver does not clear it.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            underrun <= 1'b0;
        end else if (underrun_event) begin
            underrun <= 1'b1;
        end
    end

    assign underrun_o = underrun;
`endif

    assign next_data_strobe_o = strobe;
    assign pwm_o              = pwm;
    assign state_o            = state;

endmodule

// File: tb/tb_pwm_dac_driver.sv
// Bench for pwm_dac_driver: directed period table, enable/reset cuts, then random periods against a per-period model.
module tb_pwm_dac_driver;
    import pwm_dac_driver_pkg::*;

    logic              clk = 1'b0;
    logic              rst;
    logic              enable;
    logic signed [7:0] data;
    logic              valid;
    logic              strobe;
    logic              pwm;
    state_t            state_dbg;
`ifdef PWM_UNDERRUN_FLAG_EN
    logic              underrun;
`endif

    pwm_dac_driver #(.N_FRAC(7)) dut (
        .clk_i               (clk),
        .rst_i               (rst),
        .enable_i            (enable),
        .data_i              (data),
        .data_valid_strobe_i (valid),
        .next_data_strobe_o  (strobe),
        .state_o             (state_dbg),
`ifdef PWM_UNDERRUN_FLAG_EN
        .underrun_o          (underrun),
`endif
        .pwm_o               (pwm)
    );

    always #5 clk = ~clk;

    // One PWM period of stimulus: up to two valid strobes at given offsets (-1 = none),
    // an optional cut (enable drop or reset) at cut_at (256 = none), and expected results.
    typedef struct {
        int off_a;
        int da;
        int off_b;
        int db;
        int cut_at;
        bit cut_rst;
        int exp_duty;
        bit exp_uf;
    } rec_t;

    int checks = 0;
    int errors = 0;
    int m_duty = 128;
    bit m_uf   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Period-level reference: the earliest valid strobe in offsets 1..255 sets the next duty
    // (sample + 128); none means underrun and the duty is held. Cuts discard the sample.
    task automatic model_apply(input rec_t r);
        int best;
        int bd;
        best = -1;
        bd   = 0;
        if (r.cut_at < 256) begin
            if (r.cut_rst) begin
                m_duty = 128;
                m_uf   = 1'b0;
            end
        end else begin
            if (r.off_a >= 1 && r.off_a <= 255) begin
                best = r.off_a;
                bd   = r.da;
            end
            if (r.off_b >= 1 && r.off_b <= 255 && (best < 0 || r.off_b < best)) begin
                best = r.off_b;
                bd   = r.db;
            end
            if (best >= 0) m_duty = bd + 128;
            else           m_uf   = 1'b1;
        end
    endtask

    // Entered just after the edge that starts the cycle with cnt==0.
    task automatic run_period(input rec_t r, input string tag);
        int shape_bad;
        int strobe_bad;
        int last;
        shape_bad  = 0;
        strobe_bad = 0;
        last = (r.cut_at < 256) ? r.cut_at : 255;
        for (int k = 0; k <= last; k++) begin
            valid = 1'b0;
            if (k == r.off_a) begin
                valid = 1'b1;
                data  = 8'(r.da);
            end else if (k == r.off_b) begin
                valid = 1'b1;
                data  = 8'(r.db);
            end
            if (k == r.cut_at) begin
                if (r.cut_rst) rst = 1'b0;
                else           enable = 1'b0;
            end
            @(negedge clk);
            if (pwm !== ((k > 0) && (k - 1 < r.exp_duty))) shape_bad++;
            if (strobe !== (k == 1)) strobe_bad++;
            @(posedge clk);
            #1;
        end
        valid = 1'b0;
        if (r.cut_at < 256 && r.cut_rst) rst = 1'b1;
        check({tag, " pwm_shape_errs"}, shape_bad, 0);
        check({tag, " strobe_errs"}, strobe_bad, 0);
`ifdef PWM_UNDERRUN_FLAG_EN
        check({tag, " underrun"}, underrun, r.exp_uf);
`endif
    endtask

    task automatic idle_cycles(input int n);
        int bad;
        bad = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (pwm !== 1'b0 || strobe !== 1'b0) bad++;
            @(posedge clk);
            #1;
        end
        check("disabled_outputs", bad, 0);
    endtask

    rec_t tbl[14];
    rec_t rr;

    initial begin
        //             off_a  da    off_b  db   cut  rst  duty uf
        tbl[0]  = '{     6,    0,    -1,   0,  256, 0,  128, 0};
        tbl[1]  = '{     6,    0,    -1,   0,  256, 0,  128, 0};
        tbl[2]  = '{     6, -128,    -1,   0,  256, 0,  128, 0};
        tbl[3]  = '{     6,  127,    -1,   0,  256, 0,    0, 0};
        tbl[4]  = '{    -1,    0,    -1,   0,  256, 0,  255, 1};
        tbl[5]  = '{   255,   64,    -1,   0,  256, 0,  255, 1};
        tbl[6]  = '{    10,   64,    20, -64,  256, 0,  192, 1};
        tbl[7]  = '{     0, -100,    30, -32,  256, 0,  192, 1};
        tbl[8]  = '{    20,  100,    -1,   0,  100, 0,   96, 1};
        tbl[9]  = '{    -1,    0,    -1,   0,  256, 0,   96, 1};
        tbl[10] = '{    50,    1,    -1,   0,  256, 0,   96, 1};
        tbl[11] = '{     5,   20,    -1,   0,   50, 1,  129, 0};
        tbl[12] = '{     0, -128,    40,  50,  256, 0,  128, 0};
        tbl[13] = '{    -1,    0,    -1,   0,  256, 0,  178, 1};

        rst    = 1'b0;
        enable = 1'b1;
        valid  = 1'b0;
        data   = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset pwm", pwm, 0);
        check("reset strobe", strobe, 0);
        check("reset state", state_dbg, S_IDLE);
`ifdef PWM_UNDERRUN_FLAG_EN
        check("reset underrun", underrun, 0);
`endif
        @(posedge clk);
        #1;
        rst = 1'b1;

        for (int i = 0; i < 14; i++) begin
            model_apply(tbl[i]);
            run_period(tbl[i], $sformatf("row%0d", i));
            if (tbl[i].cut_at < 256 && !tbl[i].cut_rst) begin
                idle_cycles(5);
                enable = 1'b1;
            end
        end

        for (int i = 0; i < 20; i++) begin
            rr.off_a   = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, 255));
            rr.off_b   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255)) : -1;
            if (rr.off_b == rr.off_a) rr.off_b = -1;
            rr.da      = int'($urandom_range(0, 255)) - 128;
            rr.db      = int'($urandom_range(0, 255)) - 128;
            rr.cut_at  = 256;
            rr.cut_rst = 1'b0;
            rr.exp_duty = m_duty;
            model_apply(rr);
            rr.exp_uf  = m_uf;
            run_period(rr, $sformatf("rand%0d", i));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
